two_to_one_rr_arbiter: RTL and testbench

- Upstream feeder for the 2:1 mux stage. Arbitrates two valid/ready input streams (A, B) into one registered output stream.
- Drives the mux select line registered alongside the data, so that select and data always change together.
- Round-robin fairness with a configurable burst lock. One beat per cycle at full throughput.

---
 rtl/two_to_one_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_two_to_one_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/two_to_one_rr_arbiter.sv
// rtl/two_to_one_rr_arbiter.sv - 2:1 round-robin stream arbiter with burst lock and registered mux select
// Optional per-source accepted-beat counters: define TWO_TO_ONE_RR_GRANT_CNT_EN.
module two_to_one_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
   ,output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t          pri_q, pri_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
    logic          load, grant_a, grant_b, take_a, take_b;

    assign load = !out_valid || out_ready;

    // Grant: a lone valid source wins; ties (both or neither valid) go to the priority source,
    // so an idle priority source still shows ready.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && !b_valid) begin
            grant_a = 1'b1;
        end else if (b_valid && !a_valid) begin
            grant_b = 1'b1;
        end else begin
            grant_a = (pri_q == PRI_A);
            grant_b = (pri_q == PRI_B);
        end
    end

    assign a_ready = rst_n && load && grant_a;
    assign b_ready = rst_n && load && grant_b;
    assign take_a  = a_valid && a_ready;
    assign take_b  = b_valid && b_ready;

    // Saturating increment keeps the count meaningful even when BURST fits the width exactly.
    assign cnt_sat = (cnt_q == BURST_C) ? cnt_q : cnt_q + 1'b1;

    // Priority next state: lock counts only contested beats; an uncontested win by the
    // non-priority source hands priority over with one beat already used.
    always_comb begin
        pri_d = pri_q;
        cnt_d = cnt_q;
        if (take_a) begin
            if (pri_q == PRI_A) begin
                if (b_valid) begin
                    if (cnt_sat >= BURST_C) begin
                        pri_d = PRI_B;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end else begin
                    cnt_d = '0;
                end
            end else begin
                pri_d = PRI_A;
                cnt_d = CW'(1);
            end
        end else if (take_b) begin
            if (pri_q == PRI_B) begin
                if (a_valid) begin
                    if (cnt_sat >= BURST_C) begin
                        pri_d = PRI_A;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end else begin
                    cnt_d = '0;
                end
            end else begin
                pri_d = PRI_B;
                cnt_d = CW'(1);
            end
        end
    end

    // Priority state and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_A;
            cnt_q <= '0;
        end else begin
            pri_q <= pri_d;
            cnt_q <= cnt_d;
        end
    end

    // Output register: data and select load together so the mux never sees a mismatched pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 1'b0;
        end else if (load) begin
            out_valid <= take_a || take_b;
            if (take_a) begin
                out_data <= a_data;
                sel      <= 1'b0;
            end else if (take_b) begin
                out_data <= b_data;
                sel      <= 1'b1;
            end
        end
    end

`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
    // Free-running accepted-beat counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (take_a) cnt_a <= cnt_a + 16'd1;
            if (take_b) cnt_b <= cnt_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_two_to_one_rr_arbiter.sv
// tb/tb_two_to_one_rr_arbiter.sv - directed self-checking bench for two_to_one_rr_arbiter
module tb_two_to_one_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, sel;
    logic [7:0] out_data;
`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    two_to_one_rr_arbiter #(.WIDTH(8), .BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel)
`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
       ,.cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL release_ready got=%b%b exp=10", a_ready, b_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_a_only();
        logic [7:0] d [3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = d[i];
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== d[i] || sel !== 1'b0) begin
                failures++; $display("FAIL a_only beat%0d got v=%b d=%h s=%b exp v=1 d=%h s=0", i, out_valid, out_data, sel, d[i]);
            end
        end
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL a_only_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_contention();
        int na = 0;
        int nb = 0;
        logic exp_sel;
        logic [7:0] exp_d;
        for (int i = 0; i < 12; i++) begin
            exp_sel = ((i / 4) % 2) == 1;
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = 8'(8'hA0 + na); b_data = 8'(8'hB0 + nb);
            exp_d = exp_sel ? 8'(8'hB0 + nb) : 8'(8'hA0 + na);
            #1;
            checks++; if (a_ready !== !exp_sel || b_ready !== exp_sel) begin
                failures++; $display("FAIL rr_ready beat%0d got=%b%b exp=%b%b", i, a_ready, b_ready, !exp_sel, exp_sel);
            end
            @(posedge clk);
            #1;
            checks++; if (sel !== exp_sel || out_data !== exp_d || out_valid !== 1'b1) begin
                failures++; $display("FAIL rr_out beat%0d got s=%b d=%h v=%b exp s=%b d=%h v=1", i, sel, out_data, out_valid, exp_sel, exp_d);
            end
            if (exp_sel) nb++; else na++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        a_valid = 1'b1; a_data = 8'h5A; out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_data !== 8'h5A || sel !== 1'b0) begin failures++; $display("FAIL bp_load got d=%h s=%b exp d=5a s=0", out_data, sel); end
        a_data = 8'h66; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc%0d got=%b%b exp=00", i, a_ready, b_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || sel !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc%0d got v=%b d=%h s=%b exp v=1 d=5a s=0", i, out_valid, out_data, sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", a_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin failures++; $display("FAIL bp_release_load got v=%b d=%h exp v=1 d=66", out_valid, out_data); end
        a_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        logic exp_sel;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hC1; b_data = 8'hD1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL mid_pre got v=%b s=%b exp v=1 s=0", out_valid, sel); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++; $display("FAIL mid_async got v=%b r=%b%b exp v=0 r=00", out_valid, a_ready, b_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_sel = (i == 4);
            #1;
            checks++; if (a_ready !== !exp_sel || b_ready !== exp_sel) begin
                failures++; $display("FAIL mid_after_ready beat%0d got=%b%b exp=%b%b", i, a_ready, b_ready, !exp_sel, exp_sel);
            end
            @(posedge clk);
            #1;
            checks++; if (sel !== exp_sel || out_valid !== 1'b1) begin
                failures++; $display("FAIL mid_after_sel beat%0d got s=%b v=%b exp s=%b v=1", i, sel, out_valid, exp_sel);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
    task automatic test_grant_cnt();
        rst_n = 1'b0;
        #1;
        checks++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin failures++; $display("FAIL cnt_reset got a=%h b=%h exp 0 0", cnt_a, cnt_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b_valid = 1'b0;
        checks++; if (cnt_a !== 16'd5 || cnt_b !== 16'd3) begin failures++; $display("FAIL cnt_counts got a=%0d b=%0d exp 5 3", cnt_a, cnt_b); end
        a_valid = 1'b1;
        repeat (65530) @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++; if (cnt_a !== 16'hFFFF) begin failures++; $display("FAIL cnt_full got=%h exp=ffff", cnt_a); end
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++; if (cnt_a !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", cnt_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_backpressure();
        test_reset_mid_burst();
`ifdef TWO_TO_ONE_RR_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
